// File: rtl/note_event_quantizer.sv
// note_event_quantizer: captures each finished per-voice note/rest segment and quantizes
// its cycle length to whole sixteenth notes at the current tempo, one event per segment.
module note_event_quantizer #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [4:0][7:0]  notes_in,
    input  logic [4:0][31:0] durations_in,
    input  logic [7:0]       bpm,
    input  logic             event_ready,
    output logic             event_valid,
    output logic [2:0]       event_voice,
    output logic [7:0]       event_note,
    output logic [3:0]       event_len,
    output logic             overflow_out
);
    localparam logic [40:0] SIXTEENTH   = 41'(64'(CLK_HZ) * 64'd15);
    localparam logic [40:0] SIXTEENTH_2 = 41'(64'(CLK_HZ) * 64'd30);

    typedef enum logic [1:0] {IDLE, LOAD, QUANT, EMIT} state_t;

    logic [4:0][7:0]  lastNote_q;
    logic [4:0][31:0] lastDur_q;
    logic [4:0]       pend_q;
    logic [4:0][7:0]  pendNote_q;
    logic [4:0][31:0] pendDur_q;
    logic             overflow_q;

    state_t      state_q;
    logic [2:0]  rrPtr_q;
    logic [2:0]  voice_q;
    logic [7:0]  note_q;
    logic [39:0] prod_q;
    logic [40:0] thr_q;
    logic [4:0]  k_q;
    logic [4:0]  n_q;
    logic        valid_q;
    logic [2:0]  evVoice_q;
    logic [7:0]  evNote_q;
    logic [3:0]  evLen_q;

    logic [4:0]       segEnd;
    logic [4:0]       loadClear;
    logic [4:0][31:0] durInc_d;
    logic [2:0]       grantVoice_d;
    logic [3:0]       rrIdx;
    logic [4:0]       n_d;

    always_comb begin
        segEnd    = '0;
        loadClear = '0;
        durInc_d  = '0;
        for (int i = 0; i < 5; i++) begin
            segEnd[i]    = (durations_in[i] == 32'd0) && (lastDur_q[i] != 32'd0);
            loadClear[i] = (state_q == LOAD) && (voice_q == 3'(i));
            durInc_d[i]  = (lastDur_q[i] == 32'hFFFF_FFFF) ? lastDur_q[i] : lastDur_q[i] + 32'd1;
        end
    end

    // Scan from the highest offset down so the voice nearest rrPtr_q wins.
    always_comb begin
        grantVoice_d = rrPtr_q;
        rrIdx        = '0;
        for (int j = 4; j >= 0; j--) begin
            rrIdx = 4'(rrPtr_q) + 4'(j);
            if (rrIdx >= 4'd5) rrIdx = rrIdx - 4'd5;
            if (pend_q[rrIdx[2:0]]) grantVoice_d = rrIdx[2:0];
        end
    end

    always_comb begin
        n_d = ({prod_q, 1'b0} >= thr_q) ? k_q : n_q;
    end

    // A fresh capture beats the LOAD clear on the same voice and is not an overwrite.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lastNote_q <= '1;
            lastDur_q  <= '0;
            pend_q     <= '0;
            pendNote_q <= '1;
            pendDur_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            lastNote_q <= notes_in;
            lastDur_q  <= durations_in;
            for (int i = 0; i < 5; i++) begin
                if (segEnd[i]) begin
                    pend_q[i]     <= 1'b1;
                    pendNote_q[i] <= lastNote_q[i];
                    pendDur_q[i]  <= durInc_d[i];
                    if (pend_q[i] && !loadClear[i]) overflow_q <= 1'b1;
                end else if (loadClear[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            voice_q   <= '0;
            note_q    <= 8'hFF;
            prod_q    <= '0;
            thr_q     <= '0;
            k_q       <= '0;
            n_q       <= '0;
            valid_q   <= 1'b0;
            evVoice_q <= '0;
            evNote_q  <= 8'hFF;
            evLen_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        voice_q <= grantVoice_d;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    note_q  <= pendNote_q[voice_q];
                    prod_q  <= 40'(pendDur_q[voice_q]) * 40'(bpm);
                    rrPtr_q <= (voice_q == 3'd4) ? 3'd0 : voice_q + 3'd1;
                    k_q     <= 5'd1;
                    n_q     <= 5'd0;
                    thr_q   <= SIXTEENTH;
                    state_q <= QUANT;
                end
                // thr walks the half-sixteenth points, so n lands on round-half-up(P/S).
                QUANT: begin
                    n_q   <= n_d;
                    thr_q <= thr_q + SIXTEENTH_2;
                    k_q   <= k_q + 5'd1;
                    if (k_q == 5'd16) begin
                        if (n_d == 5'd0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= EMIT;
                            valid_q   <= 1'b1;
                            evVoice_q <= voice_q;
                            evNote_q  <= note_q;
                            evLen_q   <= 4'(n_d - 5'd1);
                        end
                    end
                end
                EMIT: begin
                    if (event_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign event_valid  = valid_q;
    assign event_voice  = evVoice_q;
    assign event_note   = evNote_q;
    assign event_len    = evLen_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_note_event_quantizer.sv
// Self-checking bench for note_event_quantizer: per-voice segment streams feed a
// behavioural scoreboard of expected events, plus directed literal checks.
module tb_note_event_quantizer;
    localparam int     CLK_HZ = 1000;
    localparam longint S      = 15 * CLK_HZ;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [4:0][7:0]  notes_in;
    logic [4:0][31:0] durations_in;
    logic [7:0]       bpm;
    logic             event_ready;
    logic             event_valid;
    logic [2:0]       event_voice;
    logic [7:0]       event_note;
    logic [3:0]       event_len;
    logic             overflow_out;

    note_event_quantizer #(.CLK_HZ(CLK_HZ)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .notes_in     (notes_in),
        .durations_in (durations_in),
        .bpm          (bpm),
        .event_ready  (event_ready),
        .event_valid  (event_valid),
        .event_voice  (event_voice),
        .event_note   (event_note),
        .event_len    (event_len),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         voice;
        logic [7:0] note;
        int         len;
    } exp_t;

    exp_t expQ[$];
    int   seenVoices[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int evCount  = 0;
    int firstValidCyc = 0;
    int lastEvVoice, lastEvLen;
    logic [7:0] lastEvNote;

    logic [7:0] curNote[5];
    int         curDur[5];
    int         planLen[5];
    logic [7:0] nextNote[5];
    int         nextLen[5];
    int         endCyc[5];
    bit         randomMode  = 1'b0;
    bit         readyRandom = 1'b0;
    bit         readyLevel  = 1'b1;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(string name, longint actual, longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Round-half-up number of sixteenths, clamped at 16; zero means dropped.
    function automatic int modelLen(int segLen, int tempo);
        longint n;
        n = (2 * longint'(segLen) * tempo + S) / (2 * S);
        if (n > 16) n = 16;
        return int'(n);
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < 5; i++) begin
            if (planLen[i] != 0 && curDur[i] + 1 >= planLen[i]) begin
                int n;
                n = modelLen(planLen[i], int'(bpm));
                if (n != 0) expQ.push_back('{i, curNote[i], n - 1});
                endCyc[i] = cyc + 1;
                curDur[i] = 0;
                if (randomMode) begin
                    planLen[i] = $urandom_range(300, 1500);
                    curNote[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                end else begin
                    planLen[i] = nextLen[i];
                    curNote[i] = nextNote[i];
                    nextLen[i] = 0;
                end
            end else if (planLen[i] != 0) begin
                curDur[i]++;
            end
            notes_in[i]     = curNote[i];
            durations_in[i] = 32'(curDur[i]);
        end
        event_ready = readyRandom ? ($urandom_range(0, 3) != 0) : readyLevel;
    endtask

    task automatic runCycles(int n);
        repeat (n) begin
            @(negedge clk_in);
            applyStimulus();
        end
    endtask

    task automatic startSeg(int v, logic [7:0] note, int segLen);
        curNote[v]  = note;
        curDur[v]   = 0;
        planLen[v]  = segLen;
        nextLen[v]  = 0;
        nextNote[v] = note;
    endtask

    task automatic waitEvents(int target, int budget, string name);
        int t = 0;
        while (evCount < target && t < budget) begin
            runCycles(1);
            t++;
        end
        runCycles(1);
        checkOutput(name, longint'(evCount >= target), 1);
    endtask

    task automatic dropOlder(int v);
        int last = -1;
        for (int j = 0; j < expQ.size(); j++) if (expQ[j].voice == v) last = j;
        for (int j = expQ.size() - 1; j >= 0; j--)
            if (expQ[j].voice == v && j != last) expQ.delete(j);
    endtask

    task automatic checkResetValues(string tag);
        checkOutput({tag, "_valid"}, event_valid, 0);
        checkOutput({tag, "_voice"}, event_voice, 0);
        checkOutput({tag, "_note"}, event_note, 8'hFF);
        checkOutput({tag, "_len"}, event_len, 0);
        checkOutput({tag, "_overflow"}, overflow_out, 0);
    endtask

    // Compare process: scoreboard on every handshake, stability under backpressure.
    bit         prevHold  = 1'b0;
    bit         prevValid = 1'b0;
    logic [2:0] prevVoice;
    logic [7:0] prevNote;
    logic [3:0] prevLen;

    always @(negedge clk_in) begin
        #1;
        if (rst_in) begin
            prevHold  = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (prevHold) begin
                checkOutput("hold_valid", event_valid, 1);
                checkOutput("hold_voice", event_voice, prevVoice);
                checkOutput("hold_note", event_note, prevNote);
                checkOutput("hold_len", event_len, prevLen);
            end
            if (event_valid && !prevValid) firstValidCyc = cyc;
            if (event_valid && event_ready) begin
                int idx = -1;
                for (int j = 0; j < expQ.size(); j++)
                    if (idx < 0 && expQ[j].voice == int'(event_voice)) idx = j;
                checkOutput("event_expected", longint'(idx >= 0), 1);
                if (idx >= 0) begin
                    checkOutput("event_note", event_note, expQ[idx].note);
                    checkOutput("event_len", event_len, expQ[idx].len);
                    expQ.delete(idx);
                end
                seenVoices.push_back(int'(event_voice));
                lastEvVoice = int'(event_voice);
                lastEvNote  = event_note;
                lastEvLen   = int'(event_len);
                evCount++;
            end
            prevHold  = event_valid && !event_ready;
            prevValid = event_valid;
            prevVoice = event_voice;
            prevNote  = event_note;
            prevLen   = event_len;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog cycles=%0d limit=%0d", cyc, 90000);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t;
        int tempos[4] = '{20, 60, 137, 255};

        rst_in = 1'b1;
        bpm    = 8'd60;
        for (int i = 0; i < 5; i++) begin
            curNote[i] = 8'hFF; curDur[i] = 0; planLen[i] = 0;
            nextNote[i] = 8'hFF; nextLen[i] = 0; endCyc[i] = 0;
        end
        runCycles(3);
        checkResetValues("reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        applyStimulus();

        // 1000-cycle note on voice 0: four sixteenths, valid 18 edges after the end.
        startSeg(0, 8'h45, 1000);
        waitEvents(1, 1100, "t1000_timeout");
        checkOutput("t1000_voice", lastEvVoice, 0);
        checkOutput("t1000_note", lastEvNote, 8'h45);
        checkOutput("t1000_len", lastEvLen, 3);
        checkOutput("t1000_latency", firstValidCyc - endCyc[0], 18);

        base = evCount;
        startSeg(1, 8'h30, 124);
        runCycles(200);
        checkOutput("t124_dropped", evCount, base);

        startSeg(1, 8'h31, 125);
        waitEvents(base + 1, 300, "t125_timeout");
        checkOutput("t125_note", lastEvNote, 8'h31);
        checkOutput("t125_len", lastEvLen, 0);

        startSeg(2, 8'h52, 5000);
        waitEvents(base + 2, 5200, "t5000_timeout");
        checkOutput("t5000_voice", lastEvVoice, 2);
        checkOutput("t5000_len", lastEvLen, 15);

        startSeg(4, 8'hFF, 500);
        waitEvents(base + 3, 700, "rest_timeout");
        checkOutput("rest_voice", lastEvVoice, 4);
        checkOutput("rest_note", lastEvNote, 8'hFF);
        checkOutput("rest_len", lastEvLen, 1);

        // Simultaneous ends on 1, 3, 4 with the pointer back at 0.
        seenVoices.delete();
        startSeg(1, 8'h11, 300);
        startSeg(3, 8'h33, 300);
        startSeg(4, 8'h44, 300);
        waitEvents(base + 6, 500, "order_timeout");
        checkOutput("order_count", seenVoices.size(), 3);
        if (seenVoices.size() == 3) begin
            checkOutput("order_first", seenVoices[0], 1);
            checkOutput("order_second", seenVoices[1], 3);
            checkOutput("order_third", seenVoices[2], 4);
        end
        seenVoices.delete();
        startSeg(0, 8'h01, 300);
        startSeg(4, 8'h04, 300);
        waitEvents(base + 8, 500, "rrwrap_timeout");
        checkOutput("rrwrap_count", seenVoices.size(), 2);
        if (seenVoices.size() == 2) begin
            checkOutput("rrwrap_first", seenVoices[0], 0);
            checkOutput("rrwrap_second", seenVoices[1], 4);
        end

        // Backpressure for 50 cycles while voice 2 ends twice.
        bpm = 8'd255;
        seenVoices.delete();
        readyLevel = 1'b0;
        startSeg(0, 8'h07, 100);
        startSeg(2, 8'h21, 100000);
        t = 0;
        while (!event_valid && t < 200) begin
            runCycles(1);
            t++;
        end
        checkOutput("bp_valid_seen", event_valid, 1);
        planLen[2]  = curDur[2] + 5;
        nextNote[2] = 8'h22;
        nextLen[2]  = 40;
        runCycles(50);
        dropOlder(2);
        checkOutput("bp_overflow", overflow_out, 1);
        checkOutput("bp_still_valid", event_valid, 1);
        readyLevel = 1'b1;
        base = evCount;
        waitEvents(base + 2, 200, "bp_timeout");
        checkOutput("bp_count", seenVoices.size(), 2);
        if (seenVoices.size() == 2) begin
            checkOutput("bp_first", seenVoices[0], 0);
            checkOutput("bp_second", seenVoices[1], 2);
        end
        checkOutput("bp_note", lastEvNote, 8'h22);
        checkOutput("bp_len", lastEvLen, 0);

        // Reset in the middle of quantization.
        bpm = 8'd60;
        startSeg(1, 8'h66, 1000);
        t = 0;
        while (planLen[1] != 0 && t < 1100) begin
            runCycles(1);
            t++;
        end
        runCycles(5);
        @(negedge clk_in);
        rst_in = 1'b1;
        expQ.delete();
        applyStimulus();
        @(posedge clk_in);
        #1;
        checkResetValues("midreset");
        @(negedge clk_in);
        rst_in = 1'b0;
        applyStimulus();
        base = evCount;
        runCycles(60);
        checkOutput("midreset_no_event", evCount, base);
        checkOutput("midreset_valid_low", event_valid, 0);

        // Randomized segments on all voices, one tempo per phase.
        readyRandom = 1'b1;
        foreach (tempos[p]) begin
            bpm = 8'(tempos[p]);
            randomMode = 1'b1;
            for (int i = 0; i < 5; i++) begin
                planLen[i] = $urandom_range(300, 1500);
                curDur[i]  = $urandom_range(0, planLen[i] - 2);
                curNote[i] = 8'($urandom_range(0, 255));
                nextLen[i] = 0;
                nextNote[i] = 8'hFF;
            end
            runCycles(3000);
            randomMode = 1'b0;
            t = 0;
            while ((planLen[0] + planLen[1] + planLen[2] + planLen[3] + planLen[4] != 0 ||
                    expQ.size() != 0) && t < 4000) begin
                runCycles(1);
                t++;
            end
            checkOutput("random_drain", expQ.size(), 0);
            runCycles(150);
            checkOutput("random_overflow", overflow_out, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
